instr_packer: RTL and testbench

//  Inverse of the immediate extender: scatters a 32-bit immediate into the RISC-V

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/instr_packer_imm_scatter.sv | 47 ++++
 rtl/instr_packer.sv | 87 ++++++++
 tb/tb_instr_packer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate-format definitions for the instruction packer.
// ImmSrc encodings match the immediate extender. Each mask marks the
// instruction bits that carry immediate data in that format.
package riscv_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  // True when v fits in a signed field of the given width,
  // i.e. bits [31:width-1] are all equal.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned width);
    logic [31:0] top;
    top = $signed(v) >>> (width - 1);
    return (top == '0) || (top == '1);
  endfunction

endpackage

// File: rtl/instr_packer_imm_scatter.sv
// imm_scatter: purely combinational. Places the immediate bits into the
// instruction positions for the selected format, keeps all other template
// bits, and reports whether the immediate was representable.
module imm_scatter
  import riscv_pkg::*;
(
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] imm,
  input  logic [31:0] base_instr,
  output logic [31:0] packed_instr,
  output logic        range_ok
);

  logic [31:0] field;
  logic [31:0] mask;

  // Build the scattered immediate and its mask, then merge with the template.
  always_comb begin
    field    = '0;
    mask     = MASK_I;
    range_ok = 1'b1;
    case (ImmSrc)
      IMM_I: begin
        field    = {imm[11:0], 20'b0};
        mask     = MASK_I;
        range_ok = fits_signed(imm, 12);
      end
      IMM_S: begin
        field    = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        mask     = MASK_S;
        range_ok = fits_signed(imm, 12);
      end
      IMM_B: begin
        field    = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        mask     = MASK_B;
        range_ok = fits_signed(imm, 13) && !imm[0];
      end
      default: begin
        field    = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        mask     = MASK_J;
        range_ok = fits_signed(imm, 21) && !imm[0];
      end
    endcase
    packed_instr = (base_instr & ~mask) | (field & mask);
  end

endmodule

// File: rtl/instr_packer.sv
// instr_packer: packs immediates into instruction templates and streams the
// words to instruction memory at consecutive word addresses through a single
// output register stage. Stops accepting once DEPTH words have been taken.
// Optional feature macro: RANGE_CHECK_EN (sticky error on unrepresentable imm).
module instr_packer
  import riscv_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ImmSrc,
  input  logic [31:0]              imm,
  input  logic [31:0]              base_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     full,
  output logic                     imm_err,
  output logic [31:0]              err_addr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] packed_instr;
  logic        range_ok;
  logic        accept;
  logic [31:0] next_addr;

  imm_scatter u_scatter (
    .ImmSrc       (ImmSrc),
    .imm          (imm),
    .base_instr   (base_instr),
    .packed_instr (packed_instr),
    .range_ok     (range_ok)
  );

  assign full      = (word_count == CW'(DEPTH));
  assign in_ready  = (!out_valid || out_ready) && !full && !clear;
  assign accept    = in_valid && in_ready;
  assign next_addr = START_ADDR + 32'({word_count, 2'b00});

  // Output register stage and accepted-word counter; clear drops a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_addr   <= START_ADDR;
      out_instr  <= '0;
      word_count <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      word_count <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_addr   <= next_addr;
      out_instr  <= packed_instr;
      word_count <= word_count + CW'(1);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef RANGE_CHECK_EN
  // Sticky error flag; only the first bad word's address is kept.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      imm_err  <= 1'b0;
      err_addr <= '0;
    end else if (accept && !range_ok && !imm_err) begin
      imm_err  <= 1'b1;
      err_addr <= next_addr;
    end
  end
`else
  logic unused_range_ok;
  assign unused_range_ok = range_ok;
  assign imm_err         = 1'b0;
  assign err_addr        = '0;
`endif

endmodule

// File: tb/tb_instr_packer.sv
// Testbench for instr_packer (DEPTH=4, START_ADDR=0). Packed words are checked
// by decoding them back with an immediate extender and comparing the
// template bits; handshake and counters follow a transaction-level model.
module tb_instr_packer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0]  ImmSrc = 2'b00;
  logic [31:0] imm = '0, base_instr = '0;
  logic        in_ready, out_valid, full, imm_err;
  logic [31:0] out_addr, out_instr, err_addr;
  logic [2:0]  word_count;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_valid = 1'b0;
  logic [31:0] m_addr = START;
  logic [1:0]  m_src;
  logic [31:0] m_imm, m_base;
  int          m_count = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_err_addr = '0;
  logic [31:0] wr_q[$];

  instr_packer #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .imm(imm), .base_instr(base_instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_instr(out_instr),
    .word_count(word_count), .full(full), .imm_err(imm_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sext(logic [31:0] v, int w);
    logic signed [31:0] t;
    t = v << (32 - w);
    return t >>> (32 - w);
  endfunction

  function automatic int fwidth(logic [1:0] s);
    case (s)
      2'd0, 2'd1: return 12;
      2'd2:       return 13;
      default:    return 21;
    endcase
  endfunction

  function automatic logic [31:0] fmask(logic [1:0] s);
    case (s)
      2'd0:       return 32'hFFF0_0000;
      2'd1, 2'd2: return 32'hFE00_0F80;
      default:    return 32'hFFFF_F000;
    endcase
  endfunction

  // standard RISC-V immediate extender
  function automatic logic [31:0] extend(logic [1:0] s, logic [31:0] i);
    case (s)
      2'd0:    return {{20{i[31]}}, i[31:20]};
      2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // immediate as it survives truncation into the format
  function automatic logic [31:0] kept_imm(logic [1:0] s, logic [31:0] v);
    logic [31:0] r;
    r = sext(v, fwidth(s));
    if (s[1]) r[0] = 1'b0;
    return r;
  endfunction

  function automatic bit is_bad(logic [1:0] s, logic [31:0] v);
    return (sext(v, fwidth(s)) != v) || (s[1] && v[0]);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check in_ready, advance the model, check registered outputs.
  task automatic cyc();
    bit exp_rdy, acc;
    #1;
    exp_rdy = (!m_valid || out_ready) && (m_count != DEPTH) && !clear;
    if (!reset) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    acc = in_valid && exp_rdy && !reset;
    if (!reset && out_valid === 1'b1 && out_ready) wr_q.push_back(out_addr);
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0; m_addr = START; m_count = 0; m_err = 0; m_err_addr = '0;
    end else if (clear) begin
      m_valid = 0; m_count = 0; m_err = 0; m_err_addr = '0;
    end else if (acc) begin
      m_valid = 1;
      m_addr  = START + 32'(4 * m_count);
      m_src = ImmSrc; m_imm = imm; m_base = base_instr;
`ifdef RANGE_CHECK_EN
      if (is_bad(ImmSrc, imm) && !m_err) begin
        m_err = 1; m_err_addr = m_addr;
      end
`endif
      m_count++;
    end else if (out_ready) begin
      m_valid = 0;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("word_count", {29'b0, word_count}, 32'(m_count));
    chk("full", {31'b0, full}, {31'b0, (m_count == DEPTH)});
    chk("imm_err", {31'b0, imm_err}, {31'b0, m_err});
    chk("err_addr", err_addr, m_err_addr);
    if (m_valid) begin
      chk("out_addr", out_addr, m_addr);
      chk("imm_roundtrip", extend(m_src, out_instr), kept_imm(m_src, m_imm));
      chk("template_bits", out_instr & ~fmask(m_src), m_base & ~fmask(m_src));
    end
  endtask

  task automatic do_clear();
    in_valid = 0; clear = 1; cyc(); clear = 0;
  endtask

  task automatic rand_word(int i);
    logic [31:0] r;
    ImmSrc = 2'($urandom_range(0, 3));
    r = $urandom;
    if (i % 4 != 3) begin
      r = sext(r, fwidth(ImmSrc));
      if (ImmSrc[1]) r[0] = 1'b0;
    end
    imm = r;
    base_instr = $urandom;
  endtask

  initial begin
    // reset
    cyc(); cyc();
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, START);
    reset = 0;

    // 1: I-type imm=-1
    in_valid = 1; ImmSrc = 2'b00; imm = 32'hFFFF_FFFF; base_instr = 32'h0000_0013;
    cyc();
    in_valid = 0;
    chk("t1_instr", out_instr, 32'hFFF0_0013);
    chk("t1_addr", out_addr, START);
    cyc();
    do_clear();

    // S with imm=-2048
    in_valid = 1; ImmSrc = 2'b01; imm = 32'hFFFF_F800; base_instr = 32'h0000_2023;
    cyc();
    in_valid = 0;
    chk("s_min_instr", out_instr, 32'h8000_2023);
    cyc();

    // 2: random words, mostly representable
    for (int i = 0; i < 24; i++) begin
      if (m_count == DEPTH) do_clear();
      in_valid = 1; out_ready = ($urandom_range(0, 3) != 0);
      rand_word(i);
      cyc();
    end
    in_valid = 0; out_ready = 1; cyc();

    // 6: clear with in_valid while a write is pending
    do_clear();
    out_ready = 0; in_valid = 1; rand_word(0);
    cyc();
    clear = 1; rand_word(1);
    cyc();
    clear = 0; in_valid = 0;
    chk("t6_out_valid", {31'b0, out_valid}, 32'h0);
    out_ready = 1; cyc();

    // 3: backpressure
    do_clear();
    wr_q.delete();
    in_valid = 1; rand_word(0); cyc();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin rand_word(i); cyc(); end
    out_ready = 1;
    rand_word(1); cyc();
    rand_word(2); cyc();
    in_valid = 0; cyc(); cyc();
    chk("t3_writes", 32'(wr_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++) chk("t3_addr", wr_q[i], START + 32'(4 * i));

    // 4: fill to DEPTH with 6 offered words
    do_clear();
    wr_q.delete();
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin rand_word(i); cyc(); end
    in_valid = 0; cyc(); cyc();
    chk("t4_writes", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) chk("t4_addr", wr_q[i], START + 32'(4 * i));
    chk("t4_full", {31'b0, full}, 32'h1);
    chk("t4_in_ready", {31'b0, in_ready}, 32'h0);
    do_clear();
    chk("t4_count_clr", {29'b0, word_count}, 32'h0);
    in_valid = 1; rand_word(0); cyc(); in_valid = 0;
    chk("t4_restart_addr", out_addr, START);
    cyc();

    // 5: range errors
    do_clear();
    in_valid = 1; base_instr = 32'h0000_0013; ImmSrc = 2'b00;
    imm = 32'd5;    cyc();
    imm = 32'd7;    cyc();
    imm = 32'd2048; cyc();
    ImmSrc = 2'b10; base_instr = 32'h0000_0063; imm = 32'd3; cyc();
    in_valid = 0; cyc();
`ifdef RANGE_CHECK_EN
    chk("t5_imm_err", {31'b0, imm_err}, 32'h1);
    chk("t5_err_addr", err_addr, 32'h8);
`else
    chk("t5_imm_err", {31'b0, imm_err}, 32'h0);
    chk("t5_err_addr", err_addr, 32'h0);
`endif

    // reset mid-stream
    do_clear();
    out_ready = 0; in_valid = 1; rand_word(0); cyc();
    in_valid = 0; reset = 1; cyc();
    reset = 0;
    chk("rst_mid_instr", out_instr, 32'h0);
    chk("rst_mid_addr", out_addr, START);
    out_ready = 1; cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
